// File: rtl/chunked_wide_adder_pkg.sv
// Shared definitions for the chunked wide adder: chunk width, sequencer
// state encoding and an index-width helper.
package cwa_pkg;

  localparam int CHUNK_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cwa_state_t;

  // Ceiling log2, evaluated at elaboration time for counter widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << k) < value) result = k + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chunked_wide_adder_ppa.sv
// 6-bit Kogge-Stone parallel-prefix adder slice used by the chunk sequencer.
module PPA_adder (
  input  logic [5:0] sum_comp_1,
  input  logic [5:0] sum_comp_2,
  input  logic       c_in,
  output logic [5:0] result,
  output logic       c_out
);

  logic [5:0] w_g0;
  logic [5:0] w_p0;
  logic [5:0] w_g_lvl [0:3];
  logic [5:0] w_p_lvl [0:3];
  logic [6:0] w_carry;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_bit
      assign w_g0[gi] = sum_comp_1[gi] & sum_comp_2[gi];
      assign w_p0[gi] = sum_comp_1[gi] ^ sum_comp_2[gi];
    end
  endgenerate

  // Three prefix levels (span 1, 2, 4) cover every bit of the 6-bit slice.
  always_comb begin
    w_g_lvl[0] = w_g0;
    w_p_lvl[0] = w_p0;
    for (int l = 1; l < 4; l++) begin
      for (int i = 0; i < 6; i++) begin
        if (i >= (1 << (l - 1))) begin
          w_g_lvl[l][i] = w_g_lvl[l-1][i] | (w_p_lvl[l-1][i] & w_g_lvl[l-1][i - (1 << (l - 1))]);
          w_p_lvl[l][i] = w_p_lvl[l-1][i] & w_p_lvl[l-1][i - (1 << (l - 1))];
        end else begin
          w_g_lvl[l][i] = w_g_lvl[l-1][i];
          w_p_lvl[l][i] = w_p_lvl[l-1][i];
        end
      end
    end
  end

  assign w_carry[0] = c_in;

  generate
    for (gi = 0; gi < 6; gi++) begin : g_sum
      assign w_carry[gi+1] = w_g_lvl[3][gi] | (w_p_lvl[3][gi] & c_in);
      assign result[gi]    = w_p0[gi] ^ w_carry[gi];
    end
  endgenerate

  assign c_out = w_carry[6];

endmodule

// File: rtl/chunked_wide_adder.sv
// Multi-cycle W-bit adder: sequences 6-bit chunks, LSB first, through one
// PPA_adder slice with the carry registered between chunks.
// Optional subtract support is compiled in with the CWA_SUB_EN macro.
module chunked_wide_adder
  import cwa_pkg::*;
#(
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK_W*CHUNKS-1:0] op_a,
  input  logic [CHUNK_W*CHUNKS-1:0] op_b,
  input  logic                    c_in,
`ifdef CWA_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHUNK_W*CHUNKS-1:0] sum,
  output logic                    c_out,
  output logic                    ovf
);

  localparam int W     = CHUNK_W * CHUNKS;
  localparam int IDX_W = (clog2(CHUNKS) > 0) ? clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  cwa_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;      // shifted right one chunk per RUN cycle
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;    // partial sum, hidden until the last chunk
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_result;
  logic               w_slice_cout;
  logic               w_last;
  logic [W-1:0]       w_acc_next;
  logic [W-1:0]       w_b_capture;
  logic               w_cin_capture;

`ifdef CWA_SUB_EN
  assign w_b_capture   = sub ? ~op_b : op_b;
  assign w_cin_capture = sub ? 1'b1 : c_in;
`else
  assign w_b_capture   = op_b;
  assign w_cin_capture = c_in;
`endif

  assign w_a_chunk = r_a[CHUNK_W-1:0];
  assign w_b_chunk = r_b[CHUNK_W-1:0];
  assign w_last    = (r_idx == LAST_IDX);

  PPA_adder u_slice (
    .sum_comp_1 (w_a_chunk),
    .sum_comp_2 (w_b_chunk),
    .c_in       (r_carry),
    .result     (w_result),
    .c_out      (w_slice_cout)
  );

  // Drop the current slice result into its chunk position of the partial sum.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_idx)*CHUNK_W +: CHUNK_W] = w_result;
  end

  // Sequencer: capture, one chunk per cycle, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= w_b_capture;
            r_carry <= w_cin_capture;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_cout;
          r_a     <= r_a >> CHUNK_W;
          r_b     <= r_b >> CHUNK_W;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            // On the last chunk the slice sees the operand MSBs, so carry
            // into the MSB is a^b^sum there, and ovf is that xor carry-out.
            r_sum   <= w_acc_next;
            r_cout  <= w_slice_cout;
            r_ovf   <= w_a_chunk[CHUNK_W-1] ^ w_b_chunk[CHUNK_W-1]
                     ^ w_result[CHUNK_W-1] ^ w_slice_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // in_ready is forced low while reset is held, even though state is IDLE.
  assign in_ready  = (r_state == IDLE) & ~rst;
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Self-checking bench for chunked_wide_adder (default CHUNKS=4, W=24).
// Subtract vectors are exercised when CWA_SUB_EN is defined.
module tb_chunked_wide_adder;

  localparam int CHUNKS = 4;
  localparam int W      = 6 * CHUNKS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
`ifdef CWA_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_pass;
  int n_total;

  chunked_wide_adder #(.CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .c_in      (c_in),
`ifdef CWA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain W-bit integer arithmetic with signed-overflow rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sb);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    if (sb) begin
      full = {1'b0, a} - {1'b0, b};
      s    = full[W-1:0];
      co   = (a >= b);
      ov   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {ov, co, s};
  endfunction

  // Submit one operand set, wait for the result; lat = edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb, input logic ordy,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    op_a      = a;
    op_b      = b;
    c_in      = cin;
`ifdef CWA_SUB_EN
    sub       = sb;
`endif
    in_valid  = 1'b1;
    out_ready = ordy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = sum;
    co = c_out;
    ov = ovf;
    $display("txn a=%06h b=%06h cin=%0d sub=%0d -> sum=%06h c_out=%0d ovf=%0d lat=%0d",
             a, b, cin, sb, s, co, ov, lat);
  endtask

  vec_t vecs [0:7];
  int   n_vec;

  initial begin
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           lat;
    logic [W+1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic [W-1:0] held_sum;
    logic         saw_valid;

    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    c_in      = 1'b0;
`ifdef CWA_SUB_EN
    sub       = 1'b0;
`endif
    out_ready = 1'b0;

    n_vec = 0;
    vecs[n_vec++] = '{24'h000FFF, 24'h000001, 1'b0, 1'b0, 24'h001000, 1'b0, 1'b0};
    vecs[n_vec++] = '{24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0};
    vecs[n_vec++] = '{24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1};
    vecs[n_vec++] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1};
    vecs[n_vec++] = '{24'h123456, 24'h654321, 1'b1, 1'b0, 24'h777778, 1'b0, 1'b0};
`ifdef CWA_SUB_EN
    vecs[n_vec++] = '{24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
    vecs[n_vec++] = '{24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < n_vec; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, 1'b1, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_c_out", i), 64'(co), 64'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(CHUNKS));
    end

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef CWA_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 8 == 0) rb = ~ra;  // long carry/borrow propagation
      run_op(ra, rb, rc, rs, 1'b1, s, co, ov, lat);
      exp = model(ra, rb, rc, rs);
      check($sformatf("rand%0d", i), {31'd0, lat[7:0], ov, co, s},
            {31'd0, 8'(CHUNKS), exp[W+1], exp[W], exp[W-1:0]});
    end

    // Back-pressure: hold the result for 5 cycles, offer new operands meanwhile
    run_op(24'h0ABCDE, 24'h012345, 1'b0, 1'b0, 1'b0, s, co, ov, lat);
    exp = model(24'h0ABCDE, 24'h012345, 1'b0, 1'b0);
    check("bp_first_result", {37'd0, ov, co, s}, {37'd0, exp[W+1:0]});
    held_sum = s;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op_a     = 24'h333333;
      op_b     = 24'h444444;
      c_in     = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d_sum_stable", k), 64'(sum), 64'(held_sum));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp = model(24'h333333, 24'h444444, 1'b1, 1'b0);
    check("bp_next_result", {31'd0, lat[7:0], ovf, c_out, sum},
          {31'd0, 8'(CHUNKS), exp[W+1:0]});
    $display("txn a=333333 b=444444 cin=1 sub=0 -> sum=%06h c_out=%0d ovf=%0d lat=%0d",
             sum, c_out, ovf, lat);

    // Reset in the middle of RUN
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    op_a     = 24'hFFFFFF;
    op_b     = 24'h000001;
    c_in     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    saw_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 64'(in_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid_pulse", 64'(saw_valid), 64'd0);
    run_op(24'h00003F, 24'h000001, 1'b0, 1'b0, 1'b1, s, co, ov, lat);
    check("postrst_result", {31'd0, lat[7:0], ov, co, s},
          {31'd0, 8'(CHUNKS), 1'b0, 1'b0, 24'h000040});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
